// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep driver: FSM state encoding and
// conversions from physical units (Hz, ms) to clock-cycle counts.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  // Cycles spent in a window of the given length in milliseconds.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Cycles per half period of the tone square wave.
  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/beep_driver_tone_gen.sv
// Square-wave tone generator. The output starts low whenever it is enabled
// and toggles every HALF cycles; while disabled the tone is held low and the
// counter is cleared, so every beep starts with the same phase.
module tone_gen #(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          run;

  // The first enabled edge only arms the generator, so the first cycle of a
  // beep sees count 0 and every level of the wave lasts exactly HALF cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      run  <= 1'b0;
      tone <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      run  <= 1'b0;
      tone <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/beep_driver.sv
// Beep driver: turns a one-cycle start request into N timed beeps on a
// buzzer pin, with an LED that is high during each beep's ON window.
// Optional build macro BEEP_LONG_LAST_EN makes the final beep of every
// sequence twice as long.
module beep_driver
  import beep_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TONE_HZ = 2000,
  parameter int ON_MS   = 200,
  parameter int OFF_MS  = 200,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] beeps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             buzz,
  output logic             led
);

  localparam int HALF    = half_period(CLK_HZ, TONE_HZ);
  localparam int ON_CYC  = ms_to_cyc(CLK_HZ, ON_MS);
  localparam int OFF_CYC = ms_to_cyc(CLK_HZ, OFF_MS);

`ifdef BEEP_LONG_LAST_EN
  localparam int ON_MAX = 2 * ON_CYC;
`else
  localparam int ON_MAX = ON_CYC;
`endif

  localparam int PH_MAX = (ON_MAX > OFF_CYC) ? ON_MAX : OFF_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);
`ifdef BEEP_LONG_LAST_EN
  localparam logic [PH_W-1:0] LONG_LAST = PH_W'(2 * ON_CYC - 1);
`endif

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] remaining;
  logic [PH_W-1:0]  phase_limit;
  logic             on_end;
  logic             accept;
  logic             tone_en;

  // Last phase count of the current ON window; only the final beep may be long.
  always_comb begin
    phase_limit = ON_LAST;
`ifdef BEEP_LONG_LAST_EN
    if (remaining == CNT_W'(1)) begin
      phase_limit = LONG_LAST;
    end
`endif
  end

  assign on_end = (phase == phase_limit);
  assign accept = start && (beeps != '0) && !abort;

  // Tone enable follows the next state, so buzz drops on the same edge as led.
  always_comb begin
    tone_en = 1'b0;
    case (state)
      IDLE:    tone_en = accept;
      ON:      tone_en = !abort && !on_end;
      OFF:     tone_en = !abort && (phase == OFF_LAST);
      default: tone_en = 1'b0;
    endcase
  end

  tone_gen #(
    .HALF(HALF)
  ) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tone_en),
    .tone (buzz)
  );

  // Sequence FSM: counts ON and OFF windows and drives the registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ON;
            remaining <= beeps;
            phase     <= '0;
            busy      <= 1'b1;
            led       <= 1'b1;
          end
        end
        ON: begin
          if (abort) begin
            state     <= IDLE;
            phase     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            led       <= 1'b0;
          end else if (on_end) begin
            phase     <= '0;
            remaining <= remaining - CNT_W'(1);
            led       <= 1'b0;
            if (remaining != CNT_W'(1)) begin
              state <= OFF;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        OFF: begin
          if (abort) begin
            state     <= IDLE;
            phase     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (phase == OFF_LAST) begin
            state <= ON;
            phase <= '0;
            led   <= 1'b1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
          busy  <= 1'b0;
          led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_driver.sv
// Testbench for beep_driver with CLK_HZ=10000, TONE_HZ=1000, ON_MS=2,
// OFF_MS=1, giving HALF=5, ON_CYC=20 and OFF_CYC=10.
module tb_beep_driver;

  localparam int CNT_W    = 4;
  localparam int ON_LEN   = 20;
  localparam int OFF_LEN  = 10;
`ifdef BEEP_LONG_LAST_EN
  localparam int LAST_LEN = 40;
`else
  localparam int LAST_LEN = 20;
`endif
  localparam int MAXN = 256;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] beeps = '0;
  logic             busy, done, buzz, led;

  int checks   = 0;
  int failures = 0;

  logic led_tr  [MAXN];
  logic busy_tr [MAXN];
  logic done_tr [MAXN];
  logic buzz_tr [MAXN];

  int n_runs;
  int run_len [8];
  int gap_len [8];

  // exp packs {busy, done, buzz, led} as seen one edge after the inputs
  typedef struct {
    logic             start;
    logic [CNT_W-1:0] beeps;
    logic             abort;
    logic [3:0]       exp;
  } vec_t;

  vec_t vecs[$];

  beep_driver #(
    .CLK_HZ (10000),
    .TONE_HZ(1000),
    .ON_MS  (2),
    .OFF_MS (1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .beeps(beeps),
    .abort(abort),
    .busy (busy),
    .done (done),
    .buzz (buzz),
    .led  (led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [CNT_W-1:0] b, input logic a);
    start = s;
    beeps = b;
    abort = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles; start/abort pulse again right after the given sample index.
  task automatic capture(input int n, input int extra_start_at, input int abort_at);
    for (int i = 0; i < n; i++) begin
      tick();
      led_tr[i]  = led;
      busy_tr[i] = busy;
      done_tr[i] = done;
      buzz_tr[i] = buzz;
      start = (i == extra_start_at);
      abort = (i == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int count_ones(input logic tr [MAXN], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tr[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_high(input logic tr [MAXN], input int n);
    for (int i = 0; i < n; i++) if (tr[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int buzz_while_dark(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (buzz_tr[i] === 1'b1 && led_tr[i] !== 1'b1) c++;
    return c;
  endfunction

  task automatic led_runs(input int n);
    int cur = 0;
    int low = 0;
    n_runs = 0;
    for (int k = 0; k < 8; k++) begin
      run_len[k] = 0;
      gap_len[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (led_tr[i] === 1'b1) begin
        if (cur == 0 && n_runs > 0 && n_runs <= 8) gap_len[n_runs-1] = low;
        cur++;
        low = 0;
      end else begin
        if (cur > 0) begin
          if (n_runs < 8) run_len[n_runs] = cur;
          n_runs++;
          cur = 0;
        end
        low++;
      end
    end
    if (cur > 0) begin
      if (n_runs < 8) run_len[n_runs] = cur;
      n_runs++;
    end
  endtask

  initial begin
    vec_t v;

    // Single-beep trace: idle, start, ON window with the tone, done pulse, idle
    v = '{start: 1'b0, beeps: '0, abort: 1'b0, exp: 4'b0000};
    vecs.push_back(v);
    vecs.push_back(v);
    v = '{start: 1'b1, beeps: 4'd1, abort: 1'b0, exp: 4'b1001};
    vecs.push_back(v);
    for (int i = 1; i < LAST_LEN; i++) begin
      v = '{start: 1'b0, beeps: 4'd1, abort: 1'b0, exp: {1'b1, 1'b0, 1'((i / 5) % 2), 1'b1}};
      vecs.push_back(v);
    end
    v = '{start: 1'b0, beeps: 4'd1, abort: 1'b0, exp: 4'b0100};
    vecs.push_back(v);
    v = '{start: 1'b0, beeps: 4'd1, abort: 1'b0, exp: 4'b0000};
    vecs.push_back(v);
    vecs.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", {busy, done, buzz, led}, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_output("idle_after_reset", {busy, done, buzz, led}, 4'b0000);

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].start, vecs[k].beeps, vecs[k].abort);
      tick();
      check_output($sformatf("vec%0d", k), {busy, done, buzz, led}, vecs[k].exp);
    end

    // Three beeps
    apply_stimulus(1'b1, 4'd3, 1'b0);
    capture(120, -1, -1);
    led_runs(120);
    check_output("three_busy_rise", first_high(busy_tr, 120), 0);
    check_output("three_done_at", first_high(done_tr, 120), 2 * ON_LEN + 2 * OFF_LEN + LAST_LEN);
    check_output("three_done_count", count_ones(done_tr, 120), 1);
    check_output("three_runs", n_runs, 3);
    check_output("three_run0", run_len[0], ON_LEN);
    check_output("three_run1", run_len[1], ON_LEN);
    check_output("three_run2", run_len[2], LAST_LEN);
    check_output("three_gap0", gap_len[0], OFF_LEN);
    check_output("three_gap1", gap_len[1], OFF_LEN);
    check_output("three_buzz_dark", buzz_while_dark(120), 0);
    check_output("three_buzz_high", count_ones(buzz_tr, 120), ON_LEN + LAST_LEN / 2);

    // beeps=0 is ignored
    apply_stimulus(1'b1, 4'd0, 1'b0);
    capture(30, -1, -1);
    check_output("zero_busy", count_ones(busy_tr, 30), 0);
    check_output("zero_done", count_ones(done_tr, 30), 0);

    // Second start five cycles into a two-beep sequence is ignored
    apply_stimulus(1'b1, 4'd2, 1'b0);
    capture(100, 4, -1);
    led_runs(100);
    check_output("restart_led_total", count_ones(led_tr, 100), ON_LEN + LAST_LEN);
    check_output("restart_done", count_ones(done_tr, 100), 1);
    check_output("two_run1", run_len[1], LAST_LEN);
    check_output("two_gap0", gap_len[0], OFF_LEN);

    // Abort in the gap after the first of three beeps
    apply_stimulus(1'b1, 4'd3, 1'b0);
    capture(60, -1, 24);
    check_output("abort_off_before", {busy_tr[24], led_tr[24]}, 2'b10);
    check_output("abort_off_after", {busy_tr[25], led_tr[25], buzz_tr[25]}, 3'b000);
    check_output("abort_off_done", count_ones(done_tr, 60), 0);
    check_output("abort_off_led", count_ones(led_tr, 60), ON_LEN);

    // Abort while the tone is high
    apply_stimulus(1'b1, 4'd3, 1'b0);
    capture(40, -1, 6);
    check_output("abort_on_before", {busy_tr[6], led_tr[6], buzz_tr[6]}, 3'b111);
    check_output("abort_on_after", {busy_tr[7], led_tr[7], buzz_tr[7]}, 3'b000);
    check_output("abort_on_busy", count_ones(busy_tr, 40), 7);
    check_output("abort_on_done", count_ones(done_tr, 40), 0);

    // Abort wins over a simultaneous start in IDLE
    apply_stimulus(1'b1, 4'd3, 1'b1);
    capture(30, -1, -1);
    check_output("start_abort_busy", count_ones(busy_tr, 30), 0);
    check_output("start_abort_done", count_ones(done_tr, 30), 0);

    // Start during the done cycle is accepted
    apply_stimulus(1'b1, 4'd1, 1'b0);
    capture(100, LAST_LEN, -1);
    check_output("chain_gap", {done_tr[LAST_LEN], busy_tr[LAST_LEN], busy_tr[LAST_LEN+1]}, 3'b101);
    check_output("chain_done", count_ones(done_tr, 100), 2);
    check_output("chain_led", count_ones(led_tr, 100), 2 * LAST_LEN);

    // Asynchronous reset in the middle of an ON window
    apply_stimulus(1'b1, 4'd1, 1'b0);
    tick();
    start = 1'b0;
    repeat (6) tick();
    check_output("rst_mid_before", {busy, led, buzz}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid_async", {busy, done, buzz, led}, 4'b0000);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_output("rst_mid_idle", {busy, done, buzz, led}, 4'b0000);
    apply_stimulus(1'b1, 4'd1, 1'b0);
    tick();
    start = 1'b0;
    check_output("rst_mid_restart", {busy, done, buzz, led}, 4'b1001);
    repeat (LAST_LEN + 3) tick();
    check_output("rst_mid_final", {busy, done, buzz, led}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
